alu_serial: RTL and testbench



---
 rtl/alu_serial.sv | 187 ++++++++++++++++++
 tb/tb_alu_serial.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// Multi-cycle WIDTH-bit ALU that processes SLICE bits per cycle, LSB first, with valid/ready on both sides.
// Define ALU_SERIAL_FLAGS_EN to add the Neg and Ovf outputs.
module alu_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [2:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Zero
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             Neg,
  output logic             Ovf
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("alu_serial: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_ADD   = 3'b011,
    OP_SUB   = 3'b100,
    OP_NOTA  = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  state_e           state, state_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q, zero_q;
  logic             arith;
  logic             last_slice;
  logic [IW-1:0]    base;
  logic [SLICE-1:0] a_s, b_s, b_eff, res_s;
  logic [SLICE:0]   sum_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign last_slice = (cnt_q == CW'(N - 1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)   state_nxt = S_RUN;
      S_RUN:  if (last_slice) state_nxt = S_FIN;
      S_FIN:                  state_nxt = S_DONE;
      S_DONE: if (out_ready)  state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // One slice of the datapath, selected by the slice counter
  always_comb begin
    arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    base  = IW'(cnt_q) * IW'(SLICE);
    a_s   = a_q[base +: SLICE];
    b_s   = b_q[base +: SLICE];
    b_eff = (op_q == OP_SUB) ? ~b_s : b_s;
    sum_s = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
    res_s = '0;
    case (op_q)
      OP_AND:   res_s = a_s & b_s;
      OP_OR:    res_s = a_s | b_s;
      OP_XOR:   res_s = a_s ^ b_s;
      OP_ADD,
      OP_SUB:   res_s = sum_s[SLICE-1:0];
      OP_NOTA:  res_s = ~a_s;
      OP_PASSA: res_s = a_s;
      OP_PASSB: res_s = b_s;
      default:  res_s = '0;
    endcase
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic neg_q, ovf_q;
  logic b_msb_eff;

  // Carry into the MSB is recovered from the MSB sum bit, so no per-bit carry tracking is needed
  assign b_msb_eff = (op_q == OP_SUB) ? ~b_q[WIDTH-1] : b_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == S_FIN) begin
      neg_q <= result_q[WIDTH-1];
      ovf_q <= arith & (a_q[WIDTH-1] ^ b_msb_eff ^ result_q[WIDTH-1] ^ carry_q);
    end
  end

  assign Neg = neg_q;
  assign Ovf = ovf_q;
`endif

  // Operand capture, slice write-back and flag finalisation
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            op_q     <= op_e'(Op);
            carry_q  <= Cin;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
          end
        end
        S_RUN: begin
          result_q[base +: SLICE] <= res_s;
          if (arith) carry_q <= sum_s[SLICE];
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIN: begin
          cout_q <= arith & carry_q;
          zero_q <= (result_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign Result = result_q;
  assign Cout   = cout_q;
  assign Zero   = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: SLICE=1 and SLICE=4 instances, directed vectors with hand-computed results.
module tb_alu_serial;

  typedef struct {
    string name;
    int    res;
    int    cout;
    int    zero;
    int    neg;
    int    ovf;
    int    lat;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv1, ir1, ov1, or1, cin1, co1, z1, ng1, vf1;
  logic       iv4, ir4, ov4, or4, cin4, co4, z4, ng4, vf4;
  logic [7:0] a1, b1, r1, a4, b4, r4;
  logic [2:0] op1, op4;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;
  int acc[2];
  bit pv[2];
  sb_t q1[$];
  sb_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  alu_serial #(.WIDTH(8), .SLICE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1), .Cin(cin1), .Op(op1),
    .out_valid(ov1), .out_ready(or1), .Result(r1), .Cout(co1), .Zero(z1)
`ifdef ALU_SERIAL_FLAGS_EN
    , .Neg(ng1), .Ovf(vf1)
`endif
  );

  alu_serial #(.WIDTH(8), .SLICE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .Cin(cin4), .Op(op4),
    .out_valid(ov4), .out_ready(or4), .Result(r4), .Cout(co4), .Zero(z4)
`ifdef ALU_SERIAL_FLAGS_EN
    , .Neg(ng4), .Ovf(vf4)
`endif
  );

`ifndef ALU_SERIAL_FLAGS_EN
  assign ng1 = 1'b0;
  assign vf1 = 1'b0;
  assign ng4 = 1'b0;
  assign vf4 = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? ir1 : ir4;
  endfunction

  // Compares whatever the DUT presents against the head of its queue; pops on handshake
  task automatic mon(input int id, input logic iv, input logic ir, input logic ov, input logic orr,
                     input logic [7:0] res, input logic co, input logic z, input logic ng, input logic vf);
    sb_t e;
    if (iv && ir) acc[id] = ncyc + 1;  // number of the accepting edge
    if (ov) begin
      if ((id == 0 && q1.size() == 0) || (id == 1 && q4.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid dut%0d actual=1 required=0 result=%0h", id, res);
      end else begin
        e = (id == 0) ? q1[0] : q4[0];
        if (!pv[id]) chk({e.name, "_latency"}, ncyc - acc[id], e.lat);
        chk({e.name, "_result"}, int'(res), e.res);
        chk({e.name, "_cout"}, int'(co), e.cout);
        chk({e.name, "_zero"}, int'(z), e.zero);
        chk({e.name, "_in_ready_busy"}, int'(ir), 0);
`ifdef ALU_SERIAL_FLAGS_EN
        chk({e.name, "_neg"}, int'(ng), e.neg);
        chk({e.name, "_ovf"}, int'(vf), e.ovf);
`endif
        if (orr) begin
          if (id == 0) void'(q1.pop_front());
          else         void'(q4.pop_front());
        end
      end
    end
    pv[id] = ov;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv[0] = 1'b0;
      pv[1] = 1'b0;
    end else begin
      mon(0, iv1, ir1, ov1, or1, r1, co1, z1, ng1, vf1);
      mon(1, iv4, ir4, ov4, or4, r4, co4, z4, ng4, vf4);
    end
  end

  task automatic issue(input int id, input string nm, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, input int er, input int ec,
                       input int en, input int eo, input int elat, input bit push);
    sb_t e;
    int  n = 0;
    @(posedge clk); #1;
    while (!rdy(id) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      return;
    end
    if (push) begin
      e = '{name: nm, res: er, cout: ec, zero: (er == 0) ? 1 : 0, neg: en, ovf: eo, lat: elat};
      if (id == 0) q1.push_back(e);
      else         q4.push_back(e);
    end
    if (id == 0) begin
      iv1 = 1'b1; op1 = op; a1 = a; b1 = b; cin1 = cin;
    end else begin
      iv4 = 1'b1; op4 = op; a4 = a; b4 = b; cin4 = cin;
    end
    @(posedge clk); #1;
    // operands are free to change once accepted
    if (id == 0) begin
      iv1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom); op1 = 3'($urandom);
    end else begin
      iv4 = 1'b0; a4 = 8'($urandom); b4 = 8'($urandom); cin4 = 1'($urandom); op4 = 3'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    rst = 1'b1;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; op1 = '0;
    iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0; op4 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(ir1), 1);
    chk("reset_out_valid", int'(ov1), 0);
    chk("reset_result", int'(r1), 0);
    chk("reset_cout", int'(co1), 0);
    chk("reset_zero", int'(z1), 0);
    chk("reset4_in_ready", int'(ir4), 1);
    chk("reset4_out_valid", int'(ov4), 0);

    //     id  name          op      A      B      Cin  Res    Co Neg Ovf Lat
    issue(0, "add_ff_01",   3'b011, 8'hFF, 8'h01, 1'b0, 8'h00, 1, 0, 0, 9, 1);
    issue(0, "sub_05_07",   3'b100, 8'h05, 8'h07, 1'b1, 8'hFE, 0, 1, 0, 9, 1);
    issue(0, "sub_07_05",   3'b100, 8'h07, 8'h05, 1'b1, 8'h02, 1, 0, 0, 9, 1);
    issue(0, "sweep_and",   3'b000, 8'hA5, 8'h3C, 1'b1, 8'h24, 0, 0, 0, 9, 1);
    issue(0, "sweep_or",    3'b001, 8'hA5, 8'h3C, 1'b1, 8'hBD, 0, 1, 0, 9, 1);
    issue(0, "sweep_xor",   3'b010, 8'hA5, 8'h3C, 1'b1, 8'h99, 0, 1, 0, 9, 1);
    issue(0, "sweep_add",   3'b011, 8'hA5, 8'h3C, 1'b0, 8'hE1, 0, 1, 0, 9, 1);
    issue(0, "sweep_sub",   3'b100, 8'hA5, 8'h3C, 1'b1, 8'h69, 1, 0, 1, 9, 1);
    issue(0, "sweep_nota",  3'b101, 8'hA5, 8'h3C, 1'b1, 8'h5A, 0, 0, 0, 9, 1);
    issue(0, "sweep_passa", 3'b110, 8'hA5, 8'h3C, 1'b1, 8'hA5, 0, 1, 0, 9, 1);
    issue(0, "sweep_passb", 3'b111, 8'hA5, 8'h3C, 1'b1, 8'h3C, 0, 0, 0, 9, 1);
    issue(0, "add_7f_01",   3'b011, 8'h7F, 8'h01, 1'b0, 8'h80, 0, 1, 1, 9, 1);
    issue(0, "and_80_80",   3'b000, 8'h80, 8'h80, 1'b0, 8'h80, 0, 1, 0, 9, 1);

    // Abort an operation in its fourth RUN cycle; nothing is queued, so any out_valid is flagged
    issue(0, "aborted_add", 3'b011, 8'h12, 8'h34, 1'b0, 8'h46, 0, 0, 0, 9, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", int'(ir1), 1);
    chk("abort_out_valid", int'(ov1), 0);
    chk("abort_result", int'(r1), 0);
    issue(0, "add_01_01",   3'b011, 8'h01, 8'h01, 1'b0, 8'h02, 0, 0, 0, 9, 1);

    // SLICE=4 instance with a 10-cycle stall on the result
    or4 = 1'b0;
    issue(1, "s4_add_0f_01", 3'b011, 8'h0F, 8'h01, 1'b0, 8'h10, 0, 0, 0, 3, 1);
    n = 0;
    while (!ov4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s4_out_valid_seen", int'(ov4), 1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("s4_still_valid_after_stall", int'(ov4), 1);
    or4 = 1'b1;
    @(posedge clk); #1;
    chk("s4_out_valid_dropped", int'(ov4), 0);
    chk("s4_in_ready_back", int'(ir4), 1);

    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", q1.size() + q4.size(), 0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
